pkt_read_engine: RTL and testbench

Egress read stage downstream of the chain manager. Takes one packet descriptor (start address, length, port) at a time, streams the packet's 64-bit words out of the shared 4096×64 packet SRAM over a valid/ready interface, then pulses a release so the chain manager can free the block. Absorbs the SRAM's fixed 1-cycle read latency with a 2-entry output buffer, so it sustains one word per cycle under back-pressure.

---
 rtl/pkt_rd_pkg.sv | 36 +++
 rtl/rd_skid_fifo.sv | 61 ++++++
 rtl/pkt_read_engine.sv | 167 ++++++++++++++++
 tb/tb_pkt_read_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_rd_pkg.sv
// ============================================================================
// Module   : pkt_rd_pkg
// Brief    : Shared widths, FSM state encoding and buffer entry type for the
//            packet read engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pkt_rd_pkg;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 64;
    localparam int LEN_W      = 8;
    localparam int SRAM_DEPTH = 4096;
    localparam int TOT_W      = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } buf_entry_t;

    // A zero length field stands for the maximum packet of 2**LEN_W words.
    function automatic logic [TOT_W-1:0] decode_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? TOT_W'(1 << LEN_W) : {1'b0, len};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rd_skid_fifo.sv
// ============================================================================
// Module   : rd_skid_fifo
// Brief    : Two-entry synchronous FIFO absorbing the SRAM read latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rd_skid_fifo #(
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic [1:0]       o_occ,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_occ;
    logic             w_push_ok;
    logic             w_pop_ok;

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_pop_ok  = i_pop && (r_occ != 2'd0);
    assign w_push_ok = i_push && ((r_occ != 2'd2) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop_ok) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_occ   = r_occ;
    assign o_empty = (r_occ == 2'd0);

endmodule

`default_nettype wire

// File: rtl/pkt_read_engine.sv
// ============================================================================
// Module   : pkt_read_engine
// Brief    : Streams one packet per descriptor out of the packet SRAM over a
//            valid/ready port, then pulses a release for the chain manager.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_read_engine
    import pkt_rd_pkg::*;
#(
    parameter int ADDR_W = pkt_rd_pkg::ADDR_W,
    parameter int DATA_W = pkt_rd_pkg::DATA_W,
    parameter int LEN_W  = pkt_rd_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [3:0]        cmd_port,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [3:0]        out_port,
    output logic              free_valid,
    output logic [ADDR_W-1:0] free_addr,
    output logic [8:0]        free_len
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_base_addr;
    logic [8:0]        r_remaining;
    logic [8:0]        r_tot_len;
    logic [3:0]        r_port;
    logic              r_inflight;
    logic              r_infl_sop;
    logic              r_infl_eop;
    logic              r_free_valid;
    logic [ADDR_W-1:0] r_free_addr;
    logic [8:0]        r_free_len;

    logic              w_accept;
    logic              w_issue;
    logic              w_pop;
    logic              w_empty;
    logic              w_release;
    logic [1:0]        w_occ;
    logic [2:0]        w_used;
    logic [2:0]        w_limit;
    buf_entry_t        w_head;
    buf_entry_t        w_push_entry;

    assign w_pop     = !w_empty && out_ready;
    assign w_used    = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_limit   = 3'd2 + {2'b00, w_pop};
    assign w_release = (r_state == DRAIN) && w_pop && w_head.eop;

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        w_accept  = 1'b0;
        w_issue   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = !rst;
                w_accept  = cmd_valid && !rst;
                if (w_accept) begin
                    w_next = READ;
                end
            end
            READ: begin
                // Credit: buffered words plus the read in flight must leave room.
                w_issue = (r_remaining != 9'd0) && (w_used < w_limit);
                if (w_issue && (r_remaining == 9'd1)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_release) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr    <= '0;
            r_base_addr  <= '0;
            r_remaining  <= '0;
            r_tot_len    <= '0;
            r_port       <= '0;
            r_inflight   <= 1'b0;
            r_infl_sop   <= 1'b0;
            r_infl_eop   <= 1'b0;
            r_free_valid <= 1'b0;
            r_free_addr  <= '0;
            r_free_len   <= '0;
        end else begin
            if (w_accept) begin
                r_rd_addr   <= cmd_addr;
                r_base_addr <= cmd_addr;
                r_port      <= cmd_port;
                r_remaining <= decode_len(cmd_len);
                r_tot_len   <= decode_len(cmd_len);
            end else if (w_issue) begin
                r_rd_addr   <= r_rd_addr + 1'b1;
                r_remaining <= r_remaining - 9'd1;
            end
            r_inflight   <= w_issue;
            r_infl_sop   <= (r_remaining == r_tot_len);
            r_infl_eop   <= (r_remaining == 9'd1);
            r_free_valid <= w_release;
            if (w_release) begin
                r_free_addr <= r_base_addr;
                r_free_len  <= r_tot_len;
            end
        end
    end

    assign w_push_entry = '{data: sram_rdata, sop: r_infl_sop, eop: r_infl_eop};

    rd_skid_fifo #(
        .WIDTH ($bits(buf_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_occ   (w_occ),
        .o_empty (w_empty)
    );

    assign sram_re    = w_issue;
    assign sram_raddr = r_rd_addr;
    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? '0 : w_head.data;
    assign out_sop    = !w_empty && w_head.sop;
    assign out_eop    = !w_empty && w_head.eop;
    assign out_port   = r_port;
    assign free_valid = r_free_valid;
    assign free_addr  = r_free_addr;
    assign free_len   = r_free_len;

endmodule

`default_nettype wire

// File: tb/tb_pkt_read_engine.sv
// ============================================================================
// Module   : tb_pkt_read_engine
// Brief    : Table-driven bench for pkt_read_engine with an SRAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pkt_read_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_port;
    logic        sram_re;
    logic [11:0] sram_raddr;
    logic [63:0] sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [3:0]  out_port;
    logic        free_valid;
    logic [11:0] free_addr;
    logic [8:0]  free_len;

    pkt_read_engine dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_port   (cmd_port),
        .sram_re    (sram_re),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_port   (out_port),
        .free_valid (free_valid),
        .free_addr  (free_addr),
        .free_len   (free_len)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [11:0] a);
        return {16'hDA7A, 4'h0, a, 16'hBEEF, 4'h0, ~a};
    endfunction

    always @(posedge clk) begin
        sram_rdata <= sram_re ? mem_word(sram_raddr) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    typedef struct {
        logic [11:0] addr;
        int          cyc;
    } rd_rec_t;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [3:0]  port;
        int          cyc;
    } w_rec_t;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  len;
        logic [3:0]  port;
        bit          rnd_ready;
        int          exp_len;
    } vec_t;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    rd_rec_t     rd_q[$];
    w_rec_t      w_q[$];
    int          free_cnt = 0;
    int          free_cyc;
    logic [11:0] last_free_addr;
    logic [8:0]  last_free_len;
    logic        free_rdy;
    int          stall_err = 0;
    int          ovf_err = 0;
    bit          prev_stall = 1'b0;
    logic [65:0] prev_word;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (sram_re) rd_q.push_back('{sram_raddr, cyc});
            if (prev_stall && !(out_valid && ({out_data, out_sop, out_eop} == prev_word)))
                stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_data, out_sop, out_eop};
            if (out_valid && out_ready)
                w_q.push_back('{out_data, out_sop, out_eop, out_port, cyc});
            if (free_valid) begin
                free_cnt++;
                free_cyc       = cyc;
                last_free_addr = free_addr;
                last_free_len  = free_len;
                free_rdy       = cmd_ready;
            end
            if (dut.r_inflight && (dut.u_fifo.r_occ == 2'd2) && !(out_valid && out_ready))
                ovf_err++;
            if (dut.u_fifo.r_occ > 2'd2) ovf_err++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic run_pkt(input vec_t v, input bit timing);
        int          t0;
        int          k;
        int          fc0;
        int          n;
        int          errs;
        logic [11:0] ea;
        rd_q.delete();
        w_q.delete();
        stall_err = 0;
        fc0 = free_cnt;
        n = v.exp_len;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_port  = v.port;
        out_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = 12'($urandom);
        cmd_len   = 8'($urandom);
        cmd_port  = 4'($urandom);
        k = 0;
        while (free_cnt == fc0 && k < 3000) begin
            out_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            k++;
        end
        out_ready = 1'b1;
        chk("free_seen", free_cnt - fc0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("free_single_pulse", free_cnt - fc0, 1);
        chk("read_count", rd_q.size(), n);
        chk("word_count", w_q.size(), n);
        errs = 0;
        for (int i = 0; i < n && i < rd_q.size(); i++) begin
            ea = v.addr + 12'(i);
            if (rd_q[i].addr != ea) errs++;
        end
        chk("read_addrs", errs, 0);
        errs = 0;
        for (int i = 0; i < n && i < w_q.size(); i++) begin
            ea = v.addr + 12'(i);
            if (w_q[i].data != mem_word(ea)) errs++;
            if (w_q[i].sop != (i == 0)) errs++;
            if (w_q[i].eop != (i == n - 1)) errs++;
            if (w_q[i].port != v.port) errs++;
        end
        chk("word_content", errs, 0);
        chk("free_addr", last_free_addr, v.addr);
        chk("free_len", last_free_len, n);
        chk("cmd_ready_at_free", free_rdy, 1);
        chk("stall_stable", stall_err, 0);
        if (timing && rd_q.size() == n && w_q.size() == n) begin
            chk("first_read_cyc", rd_q[0].cyc - t0, 1);
            chk("last_read_cyc", rd_q[n-1].cyc - t0, n);
            chk("first_word_cyc", w_q[0].cyc - t0, 3);
            chk("last_word_cyc", w_q[n-1].cyc - t0, n + 2);
            chk("free_cyc", free_cyc - t0, n + 3);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int fc0;
        int k;
        vec_t v;
        vecs[0] = '{12'h010, 8'd4,   4'd3,  1'b0, 4};
        vecs[1] = '{12'h7FF, 8'd1,   4'd5,  1'b0, 1};
        vecs[2] = '{12'hFFE, 8'd4,   4'd15, 1'b0, 4};
        vecs[3] = '{12'h100, 8'd0,   4'd9,  1'b0, 256};
        vecs[4] = '{12'h200, 8'd8,   4'd6,  1'b1, 8};
        vecs[5] = '{12'hF80, 8'd200, 4'd1,  1'b1, 200};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        cmd_port = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_outputs_zero", |{sram_re, sram_raddr, out_valid, out_data, out_sop,
                                    out_eop, out_port, free_valid, free_addr, free_len}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("cmd_ready_after_reset", cmd_ready, 1);

        foreach (vecs[i]) run_pkt(vecs[i], !vecs[i].rnd_ready);

        // Reset in the middle of an 8-word packet after three words left.
        rd_q.delete();
        w_q.delete();
        wait_ready();
        cmd_valid = 1'b1;
        cmd_addr  = 12'h300;
        cmd_len   = 8'd8;
        cmd_port  = 4'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (w_q.size() < 3 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("midrst_three_words", w_q.size(), 3);
        fc0 = free_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_outputs_zero", |{sram_re, sram_raddr, out_valid, out_data, out_sop,
                                     out_eop, out_port, free_valid, free_addr, free_len}, 0);
        chk("midrst_cmd_ready_low", cmd_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_cmd_ready", cmd_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_free", free_cnt - fc0, 0);
        chk("midrst_no_output", out_valid, 0);

        v = '{12'h400, 8'd5, 4'd7, 1'b0, 5};
        run_pkt(v, 1'b1);

        chk("buffer_overflow", ovf_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
